// File: rtl/eyeriss_pkg.sv
// Shared widths, PE state encoding and config helpers for the PE datapath blocks.
package eyeriss_pkg;

  localparam int unsigned DATA_W    = 2;
  localparam int unsigned PSUM_W    = 8;
  localparam int unsigned FILT_LEN  = 3;
  localparam int unsigned IFMAP_MAX = 8;
  localparam int unsigned LEN_W     = 4;

  // Index widths for the filter tap counter and the ifmap buffer address.
  localparam int unsigned S_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned XI_W = (IFMAP_MAX > 1) ? $clog2(IFMAP_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_F,
    LOAD_X,
    MAC,
    ACC,
    OUT,
    DONE
  } pe_state_t;

  // A row length is usable only if at least one full filter window fits in the buffer.
  function automatic logic len_legal(input logic [LEN_W-1:0] w);
    return (w >= LEN_W'(FILT_LEN)) && (w <= LEN_W'(IFMAP_MAX));
  endfunction

endpackage

// File: rtl/pe_row_conv_if.sv
// Config, stream and psum handshakes between a PE compute stage and its neighbours.
interface pe_row_conv_if;
  import eyeriss_pkg::*;

  logic              cfg_start;
  logic [LEN_W-1:0]  cfg_ifmap_len;

  logic              filt_valid;
  logic              filt_ready;
  logic [DATA_W-1:0] filt_data;

  logic              ifmap_valid;
  logic              ifmap_ready;
  logic [DATA_W-1:0] ifmap_data;

  logic              psum_in_valid;
  logic              psum_in_ready;
  logic [PSUM_W-1:0] psum_in_data;

  logic              psum_out_valid;
  logic              psum_out_ready;
  logic [PSUM_W-1:0] psum_out_data;

  logic              busy;
  logic              done;
  logic              cfg_err;

  // Environment side: spad, upstream PE, downstream consumer and controller.
  modport master (
    output cfg_start, cfg_ifmap_len,
    output filt_valid, filt_data,
    output ifmap_valid, ifmap_data,
    output psum_in_valid, psum_in_data,
    output psum_out_ready,
    input  filt_ready, ifmap_ready, psum_in_ready,
    input  psum_out_valid, psum_out_data,
    input  busy, done, cfg_err
  );

  // PE compute stage side.
  modport slave (
    input  cfg_start, cfg_ifmap_len,
    input  filt_valid, filt_data,
    input  ifmap_valid, ifmap_data,
    input  psum_in_valid, psum_in_data,
    input  psum_out_ready,
    output filt_ready, ifmap_ready, psum_in_ready,
    output psum_out_valid, psum_out_data,
    output busy, done, cfg_err
  );

endinterface

// File: rtl/pe_mac_unit.sv
// Unsigned multiply with a wrapping registered accumulator.
module pe_mac_unit
  import eyeriss_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PSUM_W-1:0] acc
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod_c;

  // Full-width product of two unsigned words.
  assign prod_c = PROD_W'(a) * PROD_W'(b);

  // Accumulate on enable; clear wins so a new window always starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + PSUM_W'(prod_c);
    end
  end

endmodule

// File: rtl/pe_row_conv.sv
// Row-stationary 1-D convolution stage: load filter and ifmap rows, then emit one psum per window.
module pe_row_conv
  import eyeriss_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  pe_row_conv_if.slave bus
);

  pe_state_t         state;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  last_o;
  logic [LEN_W-1:0]  o_idx;
  logic [S_W-1:0]    s_idx;
  logic [DATA_W-1:0] f_buf [FILT_LEN];
  logic [DATA_W-1:0] x_buf [IFMAP_MAX];
  logic [PSUM_W-1:0] mac_acc;

  logic              filt_fire_c;
  logic              ifmap_fire_c;
  logic              psum_in_fire_c;
  logic              psum_out_fire_c;
  logic              last_x_c;
  logic              last_out_c;
  logic              mac_clr_c;
  logic              mac_en_c;
  logic [LEN_W-1:0]  x_idx_c;

  // Handshake transfers, qualified by state so stray valids are never consumed.
  assign filt_fire_c     = (state == LOAD_F) && bus.filt_valid    && bus.filt_ready;
  assign ifmap_fire_c    = (state == LOAD_X) && bus.ifmap_valid   && bus.ifmap_ready;
  assign psum_in_fire_c  = (state == ACC)    && bus.psum_in_valid && bus.psum_in_ready;
  assign psum_out_fire_c = (state == OUT)    && bus.psum_out_valid && bus.psum_out_ready;

  // Window bookkeeping and accumulator control.
  assign last_x_c   = (cnt == (w_len - LEN_W'(1)));
  assign last_out_c = (o_idx == last_o);
  assign x_idx_c    = o_idx + LEN_W'(s_idx);
  assign mac_en_c   = (state == MAC);
  assign mac_clr_c  = (ifmap_fire_c && last_x_c) || (psum_out_fire_c && !last_out_c);

  pe_mac_unit u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (mac_clr_c),
    .en      (mac_en_c),
    .a       (f_buf[s_idx]),
    .b       (x_buf[XI_W'(x_idx_c)]),
    .acc     (mac_acc)
  );

  // Control FSM with registered handshake/status outputs, counters and row buffers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      cnt                <= '0;
      w_len              <= '0;
      last_o             <= '0;
      o_idx              <= '0;
      s_idx              <= '0;
      f_buf              <= '{default: '0};
      x_buf              <= '{default: '0};
      bus.filt_ready     <= 1'b0;
      bus.ifmap_ready    <= 1'b0;
      bus.psum_in_ready  <= 1'b0;
      bus.psum_out_valid <= 1'b0;
      bus.psum_out_data  <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.cfg_err        <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            if (len_legal(bus.cfg_ifmap_len)) begin
              w_len          <= bus.cfg_ifmap_len;
              last_o         <= bus.cfg_ifmap_len - LEN_W'(FILT_LEN);
              cnt            <= '0;
              bus.filt_ready <= 1'b1;
              bus.busy       <= 1'b1;
              state          <= LOAD_F;
            end else begin
              bus.cfg_err <= 1'b1;
            end
          end
        end
        LOAD_F: begin
          if (filt_fire_c) begin
            f_buf[S_W'(cnt)] <= bus.filt_data;
            if (cnt == LEN_W'(FILT_LEN - 1)) begin
              cnt             <= '0;
              bus.filt_ready  <= 1'b0;
              bus.ifmap_ready <= 1'b1;
              state           <= LOAD_X;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
        end
        LOAD_X: begin
          if (ifmap_fire_c) begin
            x_buf[XI_W'(cnt)] <= bus.ifmap_data;
            if (last_x_c) begin
              cnt             <= '0;
              o_idx           <= '0;
              s_idx           <= '0;
              bus.ifmap_ready <= 1'b0;
              state           <= MAC;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
        end
        MAC: begin
          if (s_idx == S_W'(FILT_LEN - 1)) begin
            s_idx             <= '0;
            bus.psum_in_ready <= 1'b1;
            state             <= ACC;
          end else begin
            s_idx <= s_idx + S_W'(1);
          end
        end
        ACC: begin
          if (psum_in_fire_c) begin
            bus.psum_out_data  <= mac_acc + bus.psum_in_data;
            bus.psum_in_ready  <= 1'b0;
            bus.psum_out_valid <= 1'b1;
            state              <= OUT;
          end
        end
        OUT: begin
          if (psum_out_fire_c) begin
            bus.psum_out_valid <= 1'b0;
            if (last_out_c) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              o_idx <= o_idx + LEN_W'(1);
              s_idx <= '0;
              state <= MAC;
            end
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_row_conv.sv
// Directed and randomized jobs for pe_row_conv checked against a plain-arithmetic convolution model.
module tb_pe_row_conv;
  import eyeriss_pkg::*;

  typedef logic [DATA_W-1:0] fvec_t [FILT_LEN];
  typedef logic [DATA_W-1:0] xvec_t [IFMAP_MAX];
  typedef logic [PSUM_W-1:0] pvec_t [IFMAP_MAX];

  logic clk = 1'b0;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [PSUM_W-1:0] got_q [$];

  fvec_t fb, f1;
  xvec_t xb, x1, xr;
  pvec_t pz, p5, pw, pr;
  fvec_t fr;

  pe_row_conv_if bus ();

  pe_row_conv dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: dot product of the filter with window o, plus psum_in, modulo 2^PSUM_W.
  function automatic int ref_psum(input fvec_t f, input xvec_t x, input pvec_t p, input int o);
    int sum;
    sum = int'(p[o]);
    for (int s = 0; s < int'(FILT_LEN); s++) sum += int'(f[s]) * int'(x[o + s]);
    return sum % (1 << PSUM_W);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_filt_ready"},     32'(bus.filt_ready),     0);
    chk({tag, "_ifmap_ready"},    32'(bus.ifmap_ready),    0);
    chk({tag, "_psum_in_ready"},  32'(bus.psum_in_ready),  0);
    chk({tag, "_psum_out_valid"}, 32'(bus.psum_out_valid), 0);
    chk({tag, "_psum_out_data"},  32'(bus.psum_out_data),  0);
    chk({tag, "_busy"},           32'(bus.busy),           0);
    chk({tag, "_done"},           32'(bus.done),           0);
    chk({tag, "_cfg_err"},        32'(bus.cfg_err),        0);
  endtask

  task automatic cfg_bad(input int w);
    bus.cfg_ifmap_len = LEN_W'(w);
    bus.cfg_start = 1'b1;
    step();
    bus.cfg_start = 1'b0;
    chk("cfg_err_pulse", 32'(bus.cfg_err), 1);
    chk("cfg_err_busy", 32'(bus.busy), 0);
    chk("cfg_err_no_load", 32'(bus.filt_ready), 0);
    step();
    chk("cfg_err_one_cycle", 32'(bus.cfg_err), 0);
    chk("cfg_err_busy_after", 32'(bus.busy), 0);
  endtask

  task automatic start_job(input int w);
    got_q.delete();
    bus.cfg_ifmap_len = LEN_W'(w);
    bus.cfg_start = 1'b1;
    step();
    bus.cfg_start = 1'b0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_filt_ready", 32'(bus.filt_ready), 1);
  endtask

  task automatic load_f(input fvec_t f, input bit gap);
    int t;
    for (int i = 0; i < int'(FILT_LEN); i++) begin
      if (gap && $urandom_range(0, 1) == 1) begin
        bus.filt_valid = 1'b0;
        step();
      end
      bus.filt_valid = 1'b1;
      bus.filt_data  = f[i];
      t = 0;
      while (!bus.filt_ready && t < 20) begin step(); t++; end
      step();
    end
    bus.filt_valid = 1'b0;
    chk("load_f_ready_low", 32'(bus.filt_ready), 0);
    chk("load_x_ready_high", 32'(bus.ifmap_ready), 1);
  endtask

  task automatic load_x(input int w, input xvec_t x, input bit gap);
    int t;
    for (int i = 0; i < w; i++) begin
      if (gap && $urandom_range(0, 1) == 1) begin
        bus.ifmap_valid = 1'b0;
        step();
      end
      bus.ifmap_valid = 1'b1;
      bus.ifmap_data  = x[i];
      t = 0;
      while (!bus.ifmap_ready && t < 20) begin step(); t++; end
      step();
    end
    bus.ifmap_valid = 1'b0;
    chk("load_x_ready_low", 32'(bus.ifmap_ready), 0);
  endtask

  task automatic take_out(input logic [PSUM_W-1:0] pin, input int istall, input int ostall,
                          input int exp, input bit mid_cfg);
    int t;
    t = 0;
    if (mid_cfg) begin
      bus.cfg_ifmap_len = LEN_W'(3);
      bus.cfg_start = 1'b1;
    end
    while (!bus.psum_in_ready && t < 40) begin
      step();
      t++;
      if (mid_cfg && t == 1) begin
        bus.cfg_start = 1'b0;
        chk("cfg_in_mac_no_err", 32'(bus.cfg_err), 0);
        chk("cfg_in_mac_busy", 32'(bus.busy), 1);
      end
    end
    chk("psum_in_ready", 32'(bus.psum_in_ready), 1);
    chk("mac_cycles", 32'(t), FILT_LEN);
    for (int k = 0; k < istall; k++) begin
      step();
      chk("acc_stall_ready", 32'(bus.psum_in_ready), 1);
      chk("acc_stall_no_out", 32'(bus.psum_out_valid), 0);
    end
    bus.psum_in_valid = 1'b1;
    bus.psum_in_data  = pin;
    step();
    bus.psum_in_valid = 1'b0;
    chk("out_valid", 32'(bus.psum_out_valid), 1);
    chk("in_ready_drop", 32'(bus.psum_in_ready), 0);
    for (int k = 0; k < ostall; k++) begin
      step();
      chk("bp_valid_held", 32'(bus.psum_out_valid), 1);
      chk("bp_data_held", 32'(bus.psum_out_data), 32'(exp));
      chk("bp_no_filt_ready", 32'(bus.filt_ready), 0);
      chk("bp_no_ifmap_ready", 32'(bus.ifmap_ready), 0);
    end
    chk("psum_out", 32'(bus.psum_out_data), 32'(exp));
    got_q.push_back(bus.psum_out_data);
    bus.psum_out_ready = 1'b1;
    step();
    bus.psum_out_ready = 1'b0;
    chk("out_valid_drop", 32'(bus.psum_out_valid), 0);
  endtask

  task automatic run_job(input int w, input fvec_t f, input xvec_t x, input pvec_t p,
                         input int istall, input int ostall, input bit mid_cfg, input bit gap);
    int n;
    n = w - int'(FILT_LEN) + 1;
    start_job(w);
    load_f(f, gap);
    load_x(w, x, gap);
    for (int o = 0; o < n; o++) begin
      take_out(p[o], (o == 0) ? istall : 0, (o == 0) ? ostall : 0,
               ref_psum(f, x, p, o), mid_cfg && (o == 0));
    end
    chk("done_pulse", 32'(bus.done), 1);
    chk("busy_in_done", 32'(bus.busy), 1);
    step();
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("busy_low_after", 32'(bus.busy), 0);
    chk("psum_count", 32'(got_q.size()), 32'(n));
  endtask

  initial begin
    fb = '{2'd1, 2'd2, 2'd3};
    xb = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    f1 = '{2'd1, 2'd1, 2'd1};
    x1 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    pz = '{default: '0};
    p5 = '{default: 8'd5};
    pw = '{8'd250, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    reset_n            = 1'b0;
    bus.cfg_start      = 1'b0;
    bus.cfg_ifmap_len  = '0;
    bus.filt_valid     = 1'b0;
    bus.filt_data      = '0;
    bus.ifmap_valid    = 1'b0;
    bus.ifmap_data     = '0;
    bus.psum_in_valid  = 1'b0;
    bus.psum_in_data   = '0;
    bus.psum_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    step();

    // Valids presented in IDLE must not be accepted.
    bus.filt_valid = 1'b1;
    bus.ifmap_valid = 1'b1;
    bus.psum_in_valid = 1'b1;
    repeat (2) step();
    chk("idle_filt_ready", 32'(bus.filt_ready), 0);
    chk("idle_ifmap_ready", 32'(bus.ifmap_ready), 0);
    chk("idle_psum_in_ready", 32'(bus.psum_in_ready), 0);
    bus.filt_valid = 1'b0;
    bus.ifmap_valid = 1'b0;
    bus.psum_in_valid = 1'b0;

    cfg_bad(2);
    cfg_bad(9);

    run_job(5, fb, xb, pz, 0, 0, 1'b0, 1'b0);
    chk("basic_o0", 32'(got_q[0]), 8);
    chk("basic_o1", 32'(got_q[1]), 14);
    chk("basic_o2", 32'(got_q[2]), 17);

    run_job(5, fb, xb, p5, 0, 0, 1'b0, 1'b0);
    chk("accum_o0", 32'(got_q[0]), 13);
    chk("accum_o1", 32'(got_q[1]), 19);
    chk("accum_o2", 32'(got_q[2]), 22);

    run_job(5, fb, xb, pz, 0, 4, 1'b0, 1'b0);
    chk("bp_o0", 32'(got_q[0]), 8);
    chk("bp_o1", 32'(got_q[1]), 14);
    chk("bp_o2", 32'(got_q[2]), 17);

    run_job(5, fb, xb, pw, 3, 0, 1'b1, 1'b0);
    chk("wrap_o0", 32'(got_q[0]), 2);
    chk("wrap_o1", 32'(got_q[1]), 14);

    // Reset during MAC of the second window aborts the job.
    start_job(5);
    load_f(fb, 1'b0);
    load_x(5, xb, 1'b0);
    take_out(8'd0, 0, 0, 8, 1'b0);
    step();
    reset_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    step();
    reset_n = 1'b1;
    step();
    chk_zero("post_reset");
    run_job(3, f1, x1, pz, 0, 0, 1'b0, 1'b0);
    chk("after_reset_psum", 32'(got_q[0]), 6);

    for (int j = 0; j < 6; j++) begin
      int w;
      w = int'($urandom_range(int'(FILT_LEN), int'(IFMAP_MAX)));
      for (int i = 0; i < int'(FILT_LEN); i++) fr[i] = DATA_W'($urandom_range(0, 3));
      for (int i = 0; i < int'(IFMAP_MAX); i++) begin
        xr[i] = DATA_W'($urandom_range(0, 3));
        pr[i] = PSUM_W'($urandom_range(0, 255));
      end
      run_job(w, fr, xr, pr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
